branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Sequences ID-stage branch resolution in the five-stage MIPS pipeline. Detects data hazards between a branch in ID and its producers in EX/MEM. Stalls the front end for the required number of cycles and selects comparator forwarding. In the resolve cycle it issues `pc_src` and the IF/ID flush. Sits beside the hazard unit and drives the PC mux, the IF/ID and ID/EX pipeline-register controls, and the ID comparator operand muxes.

## Interface
Parameters:
- `REG_W`, 5: register-index width.
- `STAT_W`, 16: width of each statistics counter (only with `BRANCH_STATS_EN`).

Ports:
- Clock and reset: single clock `clk`; asynchronous, active-low reset `rst_n`.
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  async active-low reset.
- `id_branch`  in  2  00 none, 01 beq, 10 bne, 11 reserved (treated as none).
- `id_rs`, `id_rt`  in  REG_W  branch source registers.
- `ex_reg_write`, `ex_mem_read`  in  1  EX-stage instruction writes a register / is a load.
- `ex_rd`  in  REG_W  EX destination.
- `mem_reg_write`, `mem_mem_read`  in  1  MEM-stage equivalents.
- `mem_rd`  in  REG_W  MEM destination.
- `regs_equal`  in  1  ID comparator result on forwarded operands.
- `ext_stall`  in  1  global freeze (memory stall); all pipeline registers hold.
- `pc_write`, `ifid_write`  out  1  enable PC / IF-ID update.
- `idex_bubble`  out  1  zero ID/EX control fields.
- `ifid_flush`  out  1  clear IF/ID.
- `pc_src`  out  1  select branch target.
- `fwd_a_sel`, `fwd_b_sel`  out  2  00 register file, 01 EX/MEM ALU result, others reserved.
- `stat_taken`, `stat_stall`  out  STAT_W  counters (only with `BRANCH_STATS_EN`).

## Operation
- A source register is a hazard candidate only if it is nonzero and matches a destination whose `*_reg_write` is set.
- Stall count per source is taken from the nearest producer (EX first):
  - EX ALU: 1 cycle.
  - EX load: 2 cycles.
  - MEM load: 1 cycle.
  - MEM ALU: 0 cycles; forward with `fwd_*_sel`=01.
- The required count is the maximum over `rs` and `rt`.
- States:
  - IDLE:
    - If a branch is present with count>0, assert stall outputs this cycle (Mealy), load `cnt`=count−1, and go to WAIT when `cnt`>0.
    - If a branch is present with count=0, resolve this cycle.
  - WAIT:
    - Assert stall outputs and decrement `cnt`.
    - When `cnt`=0, return to IDLE, which re-evaluates. The producer has advanced by then, so the result is normally a resolve or a forward.
- Stall outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
- Resolve, evaluated only in IDLE with zero hazard:
  - taken = (beq & `regs_equal`) | (bne & ~`regs_equal`).
  - `pc_src`=`ifid_flush`=taken.
- `ext_stall`=1: the FSM holds state and `cnt`, and `pc_src`/`ifid_flush` are 0. Stall outputs reflect the current state unchanged.
- Non-branch in ID: outputs are at defaults; the FSM stays in IDLE.

## Timing
- While `rst_n`=0, the outputs are:
  - `pc_write`=1, `ifid_write`=1.
  - `idex_bubble`=0, `ifid_flush`=0, `pc_src`=0.
  - `fwd_*_sel`=00.
  - State IDLE, `cnt`=0, counters 0.
- Reset mid-WAIT aborts the stall immediately (asynchronous). The branch is re-evaluated after release.
- Resolve latency is 0 cycles after hazards clear. `pc_src` is combinational in the resolve cycle.
- A taken branch costs 1 cycle (flushed slot) plus stalls. A not-taken branch costs stalls only.
- `cnt` is 2 bits, saturates at 0 and never wraps.
- A branch in both WAIT and under `ext_stall` loses no cycles of counting.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `stat_taken` increments on each taken resolve with `ext_stall`=0.
  - `stat_stall` increments on each cycle with stall outputs asserted and `ext_stall`=0.
  - Both saturate at all-ones.
- Undefined: the counters and their ports are absent.

## Structure
- Shared package `branch_pkg`:
  - branch encodings (`BR_NONE`, `BR_BEQ`, `BR_BNE`).
  - FSM state enum (`BS_IDLE`, `BS_WAIT`).
  - forward-select constants (`FWD_RF`, `FWD_EXMEM`).
- One sub-module `branch_hazard_detect`: combinational per-source stall-count and forward-select computation, instantiated once for `rs` and once for `rt`.

## Test plan
- `slt $1` in EX (ALU), then `beq $1,$0` in ID → 1 stall cycle (`pc_write`=0, `idex_bubble`=1). Next cycle `fwd_a_sel`=01; `regs_equal`=1 gives `pc_src`=1 and `ifid_flush`=1.
- `lw $2` in EX, then `bne $2,$3` in ID → exactly 2 stall cycles, then resolve. With `regs_equal`=1, `pc_src`=0.
- `beq $0,$0` with EX `rd`=0 and `reg_write`=1 → no stall and immediate taken.
- `lw $4` in EX, `ext_stall` high for 3 cycles during WAIT → total stall span 5 cycles; the count still resolves correctly.
- `rst_n` pulsed low in WAIT → outputs return to reset values asynchronously and the FSM is in IDLE.
- With `BRANCH_STATS_EN`, 3 taken branches and 4 stall cycles → `stat_taken`=3, `stat_stall`=4. Preloaded to all-ones, the counters stay at all-ones.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for ID-stage branch hazard control.
// Branch encodings, forward selects, FSM states, helpers.
package branch_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;

  typedef enum logic {
    BS_IDLE = 1'b0,
    BS_WAIT = 1'b1
  } bstate_e;

  function automatic logic [1:0] max2(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Per-source stall count and comparator forward select.
// in: src, EX/MEM write/load/rd; out: need (0..2), fwd.
module branch_hazard_detect
  import branch_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       need,
  output logic [1:0]       fwd
);

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic mem_ld;
  logic mem_alu;

  assign live    = (src != '0);
  assign ex_hit  = live && ex_reg_write && (ex_rd == src);
  assign mem_hit = live && mem_reg_write && (mem_rd == src);
  // EX is the nearer producer and shadows MEM
  assign mem_ld  = !ex_hit && mem_hit && mem_mem_read;
  assign mem_alu = !ex_hit && mem_hit && !mem_mem_read;

  always_comb begin
    need = 2'd0;
    fwd  = FWD_RF;
    unique case (1'b1)
      ex_hit:  need = ex_mem_read ? 2'd2 : 2'd1;
      mem_ld:  need = 2'd1;
      mem_alu: fwd  = FWD_EXMEM;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch stall/forward/resolve sequencer.
// Ports: branch+sources, EX/MEM producers, regs_equal,
// ext_stall in; pc/ifid/idex controls, pc_src, fwd out.
// Optional BRANCH_STATS_EN adds stat_taken/stat_stall.
module branch_hazard_ctrl
  import branch_pkg::*;
#(
  parameter int REG_W = 5
`ifdef BRANCH_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       id_branch,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             regs_equal,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  bstate_e    state_q;
  bstate_e    state_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic [1:0] need_a;
  logic [1:0] need_b;
  logic [1:0] need;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       is_beq;
  logic       is_bne;
  logic       is_br;
  logic       stall;
  logic       taken;

  branch_hazard_detect #(.REG_W(REG_W)) u_det_rs (
    .src           (id_rs),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_rd        (mem_rd),
    .need          (need_a),
    .fwd           (fwd_a)
  );

  branch_hazard_detect #(.REG_W(REG_W)) u_det_rt (
    .src           (id_rt),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_rd        (mem_rd),
    .need          (need_b),
    .fwd           (fwd_b)
  );

  assign is_beq = (id_branch == BR_BEQ);
  assign is_bne = (id_branch == BR_BNE);
  assign is_br  = is_beq || is_bne;
  assign need   = max2(need_a, need_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BS_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    taken   = 1'b0;
    unique case (state_q)
      BS_IDLE: begin
        if (is_br && (need != 2'd0)) begin
          stall = 1'b1;
          if (!ext_stall) begin
            cnt_d = need - 2'd1;
            if (cnt_d != 2'd0) state_d = BS_WAIT;
          end
        end else if (is_br && !ext_stall) begin
          taken = (is_beq && regs_equal) ||
                  (is_bne && !regs_equal);
        end
      end
      BS_WAIT: begin
        stall = 1'b1;
        if (!ext_stall) begin
          cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          if (cnt_d == 2'd0) state_d = BS_IDLE;
        end
      end
      default: state_d = BS_IDLE;
    endcase
  end

  // reset forces defaults even with a branch sitting in ID
  assign pc_write    = !(stall && rst_n);
  assign ifid_write  = !(stall && rst_n);
  assign idex_bubble = stall && rst_n;
  assign pc_src      = taken && rst_n;
  assign ifid_flush  = taken && rst_n;
  assign fwd_a_sel   = (is_br && rst_n) ? fwd_a : FWD_RF;
  assign fwd_b_sel   = (is_br && rst_n) ? fwd_b : FWD_RF;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken <= '0;
      stat_stall <= '0;
    end else begin
      if (taken && !(&stat_taken))
        stat_taken <= stat_taken + STAT_W'(1);
      if (stall && !ext_stall && !(&stat_stall))
        stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl.
// Directed scenarios then random cycles vs. a cycle-count model.
module tb_branch_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] id_branch;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       ex_reg_write, ex_mem_read;
  logic       mem_reg_write, mem_mem_read;
  logic       regs_equal, ext_stall;
  logic       pc_write, ifid_write, idex_bubble;
  logic       ifid_flush, pc_src;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef BRANCH_STATS_EN
  logic [3:0] stat_taken, stat_stall;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_pend   = 0;
  int m_st_t   = 0;
  int m_st_s   = 0;

  branch_hazard_ctrl #(
    .REG_W(5)
`ifdef BRANCH_STATS_EN
    , .STAT_W(4)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_branch     (id_branch),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_rd        (mem_rd),
    .regs_equal    (regs_equal),
    .ext_stall     (ext_stall),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .idex_bubble   (idex_bubble),
    .ifid_flush    (ifid_flush),
    .pc_src        (pc_src),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken    (stat_taken),
    .stat_stall    (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  // cycles a source must wait, from the nearest producer
  function automatic int need_of(input logic [4:0] s);
    if (s == 0) return 0;
    if (ex_reg_write && ex_rd == s)
      return ex_mem_read ? 2 : 1;
    if (mem_reg_write && mem_rd == s)
      return mem_mem_read ? 1 : 0;
    return 0;
  endfunction

  function automatic int fwd_of(input logic [4:0] s);
    if (s == 0) return 0;
    if (ex_reg_write && ex_rd == s) return 0;
    if (mem_reg_write && mem_rd == s && !mem_mem_read)
      return 1;
    return 0;
  endfunction

  task automatic step(input int br, input int rs,
                      input int rt, input int exw,
                      input int exl, input int exrd,
                      input int mw, input int ml,
                      input int mrd, input int eq,
                      input int ext, input int rst);
    int n;
    bit e_stall, e_taken, isbr;
    logic [8:0] exp, got;
    id_branch     = 2'(br);
    id_rs         = 5'(rs);
    id_rt         = 5'(rt);
    ex_reg_write  = exw[0];
    ex_mem_read   = exl[0];
    ex_rd         = 5'(exrd);
    mem_reg_write = mw[0];
    mem_mem_read  = ml[0];
    mem_rd        = 5'(mrd);
    regs_equal    = eq[0];
    ext_stall     = ext[0];
    rst_n         = rst[0];
    #2;
    if (!rst) m_pend = 0;
    isbr = (br == 1) || (br == 2);
    n = need_of(5'(rs));
    if (need_of(5'(rt)) > n) n = need_of(5'(rt));
    e_stall = 0;
    e_taken = 0;
    if (rst) begin
      if (m_pend > 0) e_stall = 1;
      else if (isbr && n > 0) e_stall = 1;
      else if (isbr && !ext)
        e_taken = (br == 1 && eq != 0) || (br == 2 && eq == 0);
    end
    exp = {!e_stall, !e_stall, e_stall, e_taken, e_taken,
           (rst && isbr) ? 2'(fwd_of(5'(rs))) : 2'd0,
           (rst && isbr) ? 2'(fwd_of(5'(rt))) : 2'd0};
    got = {pc_write, ifid_write, idex_bubble, ifid_flush,
           pc_src, fwd_a_sel, fwd_b_sel};
    chk("outs", 32'(got), 32'(exp));
`ifdef BRANCH_STATS_EN
    if (!rst) begin
      m_st_t = 0;
      m_st_s = 0;
    end
    chk("stat_taken", 32'(stat_taken), 32'(m_st_t));
    chk("stat_stall", 32'(stat_stall), 32'(m_st_s));
`endif
    @(posedge clk);
    if (!rst) begin
      m_pend = 0;
      m_st_t = 0;
      m_st_s = 0;
    end else if (!ext) begin
      if (m_pend > 0) m_pend--;
      else if (e_stall) m_pend = n - 1;
      if (e_taken && m_st_t < 15) m_st_t++;
      if (e_stall && m_st_s < 15) m_st_s++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst_n = 0;
    id_branch = 0; id_rs = 0; id_rt = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_rd = 0;
    regs_equal = 0; ext_stall = 0;
    @(posedge clk); #1;
    // reset with a hazardous branch present
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // slt $1 in EX, then forwarded taken beq
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1);
    // lw $2 in EX, bne $2,$3: two stalls, not taken
    step(2, 2, 3, 1, 1, 2, 0, 0, 0, 1, 0, 1);
    step(2, 2, 3, 0, 0, 0, 1, 1, 2, 1, 0, 1);
    step(2, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    // beq $0,$0 with EX rd=0 writing: taken at once
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    // lw $4, ext_stall for 3 cycles during WAIT
    step(1, 4, 5, 1, 1, 4, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 4, 5, 0, 0, 0, 1, 1, 4, 0, 1, 1);
    step(1, 4, 5, 0, 0, 0, 1, 1, 4, 0, 0, 1);
    step(1, 4, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    // reset pulse in WAIT, then re-evaluation
    step(2, 6, 0, 1, 1, 6, 0, 0, 0, 0, 0, 1);
    step(2, 6, 0, 0, 0, 0, 1, 1, 6, 0, 0, 0);
    step(2, 6, 0, 1, 1, 6, 0, 0, 0, 0, 0, 1);
    step(2, 6, 0, 0, 0, 0, 1, 1, 6, 0, 0, 1);
    step(2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reserved encoding behaves as no branch
    step(3, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1);
    // random traffic over a small register window
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1),
           ($urandom_range(0, 4) == 0) ? 1 : 0,
           ($urandom_range(0, 39) == 0) ? 0 : 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
